display_writer: RTL
===================

DISPLAY_WRITER -- requirements
Module: display_writer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of characters buffered ahead of the seven-segment decoder.
REQ-002 The block SHALL have parameter BLANK_CODE, default 6'h3F, giving the 6-bit character code written to a slot to blank it.
REQ-003 The block SHALL have port clk_100Mhz, input, 1 bit: the single 100 MHz clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream has a decoded character on in_char.
REQ-006 The block SHALL have port in_char, input, 6 bits: the character code from the Morse receiver.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a character this cycle.
REQ-008 The block SHALL have port clear, input, 1 bit: a single-cycle request to blank all 8 display slots.
REQ-009 The block SHALL have port data_valid, output, 1 bit: write strobe to the decoder.
REQ-010 The block SHALL have port char_index, output, 3 bits: the decoder slot being written.
REQ-011 The block SHALL have port char_data, output, 6 bits: the code written to that slot.
REQ-012 The block SHALL have port cursor, output, 3 bits: the next slot to receive a character.
REQ-013 The block SHALL have port fifo_count, output, 3 bits: the number of buffered characters, 0..FIFO_DEPTH.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the FSM is not IDLE or a clear is pending.

Function
REQ-015 Accept: a character SHALL be pushed into the FIFO on any rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal (fifo_count < FIFO_DEPTH), computed from the registered count only.
REQ-016 Push and pop on the same edge SHALL leave fifo_count unchanged; when full, in_ready=0 even if a pop occurs that edge.
REQ-017 The FSM SHALL have states IDLE, WRITE and CLEAR; data_valid, char_index and char_data SHALL be registered outputs.
REQ-018 IDLE -> CLEAR when clear_pending=1; otherwise IDLE -> WRITE when fifo_count>0. Clear SHALL have priority over buffered characters.
REQ-019 WRITE: each cycle pop the FIFO head and drive data_valid=1, char_index=cursor, char_data=head; cursor SHALL then increment modulo 8 (7 wraps to 0).
REQ-020 WRITE SHALL continue one character per cycle while the FIFO is non-empty and no clear is pending; otherwise it SHALL return to IDLE.
REQ-021 Latency: with the FIFO empty and the FSM in IDLE, a character accepted at edge k SHALL appear with data_valid=1 for exactly the cycle following edge k+1.
REQ-022 A clear pulse SHALL set the sticky clear_pending; clear_pending SHALL be released when CLEAR is entered.
REQ-023 A clear asserted while already in CLEAR SHALL be ignored.
REQ-024 CLEAR SHALL write BLANK_CODE to char_index 0,1,...,7 on 8 consecutive cycles with data_valid=1, then set cursor=0 and return to IDLE.
REQ-025 Characters accepted during CLEAR SHALL remain buffered and be written afterwards, starting at slot 0.
REQ-026 In IDLE, data_valid SHALL be 0; char_index and char_data SHALL hold their last values.
REQ-027 fifo_count arithmetic SHALL never wrap: there is no push when full and no pop when empty.

Reset
REQ-028 While reset=0, the block SHALL hold: state=IDLE, FIFO empty, fifo_count=0, cursor=0, clear_pending=0, data_valid=0, char_index=0, char_data=0, busy=0, in_ready=1.
REQ-029 Reset asserted mid-WRITE or mid-CLEAR SHALL abort immediately, discard buffered characters, and produce no further data_valid pulse.

Verification
REQ-030 Single char: after reset, in_char=6'h05 accepted at edge k -> one data_valid pulse after edge k+1 with char_index=0, char_data=6'h05; cursor=1.
REQ-031 Burst and wrap: 10 back-to-back chars 1..10 -> writes to slots 0..7, then 0,1; at most one strobe per cycle; cursor=2 at the end.
REQ-032 Backpressure: hold the FSM in CLEAR and offer 6 chars -> in_ready drops after 4; fifo_count=4; no char is lost or duplicated.
REQ-033 Clear priority: pulse clear with 3 chars buffered -> 8 BLANK_CODE writes to slots 0..7 first, then the 3 chars to slots 0,1,2.
REQ-034 Reset mid-burst: drive reset low during WRITE with fifo_count=3 -> data_valid=0 the same cycle; after release, fifo_count=0 and cursor=0.
REQ-035 Simultaneous push and pop at fifo_count=2 -> fifo_count stays 2; in_ready stays 1.

Source files
------------

// File: rtl/display_writer.sv
// display_writer: buffers decoded Morse characters and writes them
// to the 8-slot seven-segment decoder, with a sticky full-display clear.
module display_writer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [5:0]  BLANK_CODE = 6'h3F
) (
   input  logic       clk_100Mhz,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [5:0] in_char,
   output logic       in_ready,
   input  logic       clear,
   output logic       data_valid,
   output logic [2:0] char_index,
   output logic [5:0] char_data,
   output logic [2:0] cursor,
   output logic [2:0] fifo_count,
   output logic       busy
);

   localparam int unsigned PW =
      (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [2:0]    DEPTH = 3'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST  = PW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      CLEAR
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          clear_pending;
   logic [2:0]    clr_idx_q, clr_idx_d;
   logic          push, pop, clr_ack;
   logic          dv_d;
   logic [2:0]    idx_d, cur_d;
   logic [5:0]    dat_d;

   // Ready depends only on the registered count, never on a pop.
   assign in_ready = (fifo_count < DEPTH);
   assign push     = in_valid & in_ready;
   assign busy     = (state_q != IDLE) | clear_pending;

   // Character storage; emptiness is tracked by the count, not the data.
   always_ff @(posedge clk_100Mhz) begin
      if (push) mem[wr_ptr] <= in_char;
   end

   // FIFO pointers, occupancy and the sticky clear request.
   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= 3'd0;
         clear_pending <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         if (push && !pop)
            fifo_count <= fifo_count + 3'd1;
         else if (pop && !push)
            fifo_count <= fifo_count - 3'd1;
         if (clr_ack)
            clear_pending <= 1'b0;
         else if (clear && state_q != CLEAR)
            clear_pending <= 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and next write strobe; each write issues on the
   // transition edge so a character reaches the decoder one edge after
   // it is accepted.
   always_comb begin
      state_d   = state_q;
      dv_d      = 1'b0;
      idx_d     = char_index;
      dat_d     = char_data;
      cur_d     = cursor;
      clr_idx_d = clr_idx_q;
      pop       = 1'b0;
      clr_ack   = 1'b0;
      unique case (state_q)
         IDLE, WRITE: begin
            if (clear_pending) begin
               if (state_q == IDLE) begin
                  state_d   = CLEAR;
                  clr_ack   = 1'b1;
                  dv_d      = 1'b1;
                  idx_d     = 3'd0;
                  dat_d     = BLANK_CODE;
                  clr_idx_d = 3'd1;
               end else begin
                  state_d = IDLE;
               end
            end else if (fifo_count != 3'd0) begin
               state_d = WRITE;
               pop     = 1'b1;
               dv_d    = 1'b1;
               idx_d   = cursor;
               dat_d   = mem[rd_ptr];
               cur_d   = cursor + 3'd1;
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            dv_d      = 1'b1;
            idx_d     = clr_idx_q;
            dat_d     = BLANK_CODE;
            clr_idx_d = clr_idx_q + 3'd1;
            if (clr_idx_q == 3'd7) begin
               state_d = IDLE;
               cur_d   = 3'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered decoder outputs, cursor and blanking slot counter.
   always_ff @(posedge clk_100Mhz or negedge reset) begin
      if (!reset) begin
         data_valid <= 1'b0;
         char_index <= 3'd0;
         char_data  <= 6'd0;
         cursor     <= 3'd0;
         clr_idx_q  <= 3'd0;
      end else begin
         data_valid <= dv_d;
         char_index <= idx_d;
         char_data  <= dat_d;
         cursor     <= cur_d;
         clr_idx_q  <= clr_idx_d;
      end
   end

endmodule
